llkid_key_sender: RTL and testbench
===================================

LLKID_KEY_SENDER -- requirements
Module: llkid_key_sender

Interface
REQ-001 SHALL have parameter KEY_WORDS, default 5, number of 64-bit words per key load.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum wait cycles per handshake phase.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_load  input  1  single-cycle request to load key_in.
REQ-006 SHALL have port cmd_clear  input  1  single-cycle request to clear the remote key.
REQ-007 SHALL have port key_in  input  64*KEY_WORDS  key to send; word i = key_in[64*i+63:64*i].
REQ-008 SHALL have port llkid_key_data  output  64  current key word.
REQ-009 SHALL have port llkid_key_valid  output  1  key word valid.
REQ-010 SHALL have port llkid_key_ready  input  1  responder accepts word.
REQ-011 SHALL have port llkid_key_complete  input  1  responder holds full key.
REQ-012 SHALL have port llkid_clear_key  output  1  clear request.
REQ-013 SHALL have port llkid_clear_key_ack  input  1  clear acknowledged.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-016 SHALL have port status  output  2  last result: 0 none, 1 ok, 2 load timeout, 3 clear timeout.

Function
REQ-017 SHALL implement states IDLE, SEND, WAIT_COMPLETE, CLEAR.
REQ-018 In IDLE, cmd_load SHALL capture key_in into an internal register, zero word index, clear timeout counter, and enter SEND next cycle.
REQ-019 In IDLE, cmd_clear SHALL enter CLEAR next cycle; cmd_clear and cmd_load in the same cycle SHALL give clear priority and ignore the load.
REQ-020 Commands outside IDLE SHALL be ignored without status change.
REQ-021 In SEND, llkid_key_valid SHALL be 1 and llkid_key_data SHALL be captured word[index], stable until transfer.
REQ-022 A transfer SHALL occur in a cycle where llkid_key_valid and llkid_key_ready are both 1; index then increments and the timeout counter zeroes.
REQ-023 After the transfer of word KEY_WORDS-1, valid SHALL drop the next cycle and state SHALL become WAIT_COMPLETE; valid SHALL never be high outside SEND.
REQ-024 Back-to-back transfers SHALL sustain one word per cycle when ready is held high; a KEY_WORDS load then takes exactly KEY_WORDS cycles in SEND.
REQ-025 In WAIT_COMPLETE, llkid_key_complete=1 SHALL set status=1, pulse done, and return to IDLE next cycle.
REQ-026 In CLEAR, llkid_clear_key SHALL be 1; llkid_clear_key_ack=1 SHALL drop clear_key next cycle, set status=1, pulse done, and return to IDLE.
REQ-027 The timeout counter SHALL increment each cycle in SEND, WAIT_COMPLETE, and CLEAR without progress and zero on state entry and on each transfer.
REQ-028 A counter reaching TIMEOUT_CYCLES-1 without progress SHALL deassert valid/clear_key next cycle, set status=2 (SEND/WAIT_COMPLETE) or 3 (CLEAR), return to IDLE, and not pulse done.
REQ-029 Progress and timeout in the same cycle SHALL resolve as progress.
REQ-030 status SHALL hold until the next accepted command, which SHALL set it to 0.
REQ-031 key_in changes after capture SHALL not affect words being sent.

Reset
REQ-032 rst=1 SHALL force IDLE, llkid_key_valid=0, llkid_clear_key=0, llkid_key_data=0, busy=0, done=0, status=0, index and counter=0, including mid-load or mid-clear.
REQ-033 Commands asserted while rst=1 SHALL be ignored.

Verification
REQ-034 Load, ready held 1, KEY_WORDS=5, key_in words 0x11..,0x22..,0x33..,0x44..,0x55.. -> five consecutive transfers in order, complete=1 -> done pulse, status=1.
REQ-035 Load with ready toggling 1,0,0,1 per word -> data held stable across stalls, exactly 5 transfers, no duplicates or skips.
REQ-036 Load, complete never asserted, TIMEOUT_CYCLES=16 -> status=2 after 16 idle cycles in WAIT_COMPLETE, no done, busy=0.
REQ-037 cmd_load and cmd_clear same cycle, ack after 3 cycles -> clear_key high 3 cycles, valid never high, done, status=1.
REQ-038 rst asserted after 2 of 5 words -> outputs at reset values next cycle; subsequent load restarts at word 0.
REQ-039 cmd_load while busy -> ignored; in-flight load finishes unchanged.

Source files
------------

// File: rtl/llkid_key_sender.sv
// Key sender: captures a multi-word key and streams it to a responder over a
// valid/ready handshake, or requests a remote key clear, with per-phase timeouts.
module llkid_key_sender #(
    parameter int KEY_WORDS      = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_load,
    input  logic                    cmd_clear,
    input  logic [64*KEY_WORDS-1:0] key_in,
    output logic [63:0]             llkid_key_data,
    output logic                    llkid_key_valid,
    input  logic                    llkid_key_ready,
    input  logic                    llkid_key_complete,
    output logic                    llkid_clear_key,
    input  logic                    llkid_clear_key_ack,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              status
);

    localparam int IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE          = 2'd0;
    localparam logic [1:0] ST_SEND          = 2'd1;
    localparam logic [1:0] ST_WAIT_COMPLETE = 2'd2;
    localparam logic [1:0] ST_CLEAR         = 2'd3;

    localparam logic [1:0] STATUS_NONE      = 2'd0;
    localparam logic [1:0] STATUS_OK        = 2'd1;
    localparam logic [1:0] STATUS_LOAD_TO   = 2'd2;
    localparam logic [1:0] STATUS_CLEAR_TO  = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]                   state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [KEY_WORDS-1:0][63:0]   key_q, key_d;
    logic [1:0]                   status_q, status_d;
    logic                         done_q, done_d;
    logic                         timed_out;

    assign timed_out = (cnt_q == LAST_CNT);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        status_d = status_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Clear wins over a simultaneous load.
                if (cmd_clear) begin
                    state_d  = ST_CLEAR;
                    cnt_d    = '0;
                    status_d = STATUS_NONE;
                end else if (cmd_load) begin
                    state_d  = ST_SEND;
                    key_d    = key_in;
                    idx_d    = '0;
                    cnt_d    = '0;
                    status_d = STATUS_NONE;
                end
            end
            ST_SEND: begin
                if (llkid_key_ready) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_WAIT_COMPLETE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (timed_out) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    status_d = STATUS_LOAD_TO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_COMPLETE: begin
                if (llkid_key_complete) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    status_d = STATUS_OK;
                    done_d   = 1'b1;
                end else if (timed_out) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    status_d = STATUS_LOAD_TO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (llkid_clear_key_ack) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    status_d = STATUS_OK;
                    done_d   = 1'b1;
                end else if (timed_out) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    status_d = STATUS_CLEAR_TO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            key_q    <= '0;
            status_q <= STATUS_NONE;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    // Handshake outputs are pure state decodes, so they drop the cycle the state leaves.
    assign llkid_key_valid = (state_q == ST_SEND);
    assign llkid_key_data  = (state_q == ST_SEND) ? key_q[idx_q] : 64'd0;
    assign llkid_clear_key = (state_q == ST_CLEAR);
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign status          = status_q;

endmodule

// File: tb/tb_llkid_key_sender.sv
// Self-checking bench for llkid_key_sender: randomized keys and handshake timing
// checked against expectations derived from the key words and cycle arithmetic.
module tb_llkid_key_sender;

    localparam int KW = 5;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_load;
    logic              cmd_clear;
    logic [64*KW-1:0]  key_in;
    logic [63:0]       llkid_key_data;
    logic              llkid_key_valid;
    logic              llkid_key_ready;
    logic              llkid_key_complete;
    logic              llkid_clear_key;
    logic              llkid_clear_key_ack;
    logic              busy;
    logic              done;
    logic [1:0]        status;

    int total  = 0;
    int passed = 0;

    llkid_key_sender #(.KEY_WORDS(KW), .TIMEOUT_CYCLES(TO)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_load            (cmd_load),
        .cmd_clear           (cmd_clear),
        .key_in              (key_in),
        .llkid_key_data      (llkid_key_data),
        .llkid_key_valid     (llkid_key_valid),
        .llkid_key_ready     (llkid_key_ready),
        .llkid_key_complete  (llkid_key_complete),
        .llkid_clear_key     (llkid_clear_key),
        .llkid_clear_key_ack (llkid_clear_key_ack),
        .busy                (busy),
        .done                (done),
        .status              (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [64*KW-1:0] rand_key();
        logic [64*KW-1:0] k;
        for (int i = 0; i < KW; i++) k[64*i +: 64] = {$urandom, $urandom};
        return k;
    endfunction

    // mode 0: ready held high; 1: ready 1,0,0,1 repeating; 2: random ready;
    // 3: each word stalled exactly TO-1 cycles before ready (progress at the timeout edge).
    task automatic run_load(input logic [64*KW-1:0] key, input int mode, input int cdelay,
                            input bit inject, input bit expect_to);
        logic [63:0] exp_q[$];
        logic [63:0] got_q[$];
        logic [63:0] held;
        bit          holding = 0;
        bit          r;
        int          cyc = 0, send_cycles = 0, stall_run = 0, clr_seen = 0, n = 0, dones = 0;
        for (int i = 0; i < KW; i++) exp_q.push_back(key[64*i +: 64]);
        key_in   = key;
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        key_in   = rand_key();
        check("load_busy", busy, 1);
        check("load_status_zero", status, 0);
        while (got_q.size() < KW && cyc < 400) begin
            if (llkid_clear_key) clr_seen++;
            if (holding && llkid_key_valid) check("stall_data_hold", llkid_key_data, held);
            if (llkid_key_valid) send_cycles++;
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       r = 1'($urandom_range(0, 1));
                default: r = (stall_run == TO - 1);
            endcase
            if (inject && cyc == 2) begin
                cmd_load  = 1'b1;
                cmd_clear = 1'b1;
                key_in    = rand_key();
            end
            llkid_key_ready = r;
            if (llkid_key_valid && r) begin
                got_q.push_back(llkid_key_data);
                holding   = 0;
                stall_run = 0;
            end else if (llkid_key_valid) begin
                holding   = 1;
                held      = llkid_key_data;
                stall_run++;
            end
            @(negedge clk);
            cmd_load  = 1'b0;
            cmd_clear = 1'b0;
            cyc++;
        end
        llkid_key_ready = 1'b0;
        check("xfer_count", 64'(got_q.size()), KW);
        for (int i = 0; i < KW && i < got_q.size(); i++) check("xfer_word", got_q[i], exp_q[i]);
        if (mode == 0) check("send_cycles", 64'(send_cycles), KW);
        check("no_clear_during_load", 64'(clr_seen), 0);
        check("valid_drop_after_last", llkid_key_valid, 0);
        check("busy_in_wait", busy, 1);
        if (expect_to) begin
            while (busy && n < 100) begin
                if (done) dones++;
                if (llkid_key_valid) dones++;
                @(negedge clk);
                n++;
            end
            check("wait_timeout_cycles", 64'(n), TO);
            check("wait_timeout_status", status, 2);
            check("wait_timeout_no_done", 64'(dones), 0);
            check("wait_timeout_done_low", done, 0);
            check("wait_timeout_idle", busy, 0);
        end else begin
            repeat (cdelay) @(negedge clk);
            check("still_waiting", busy, 1);
            llkid_key_complete = 1'b1;
            @(negedge clk);
            llkid_key_complete = 1'b0;
            check("complete_done", done, 1);
            check("complete_status", status, 1);
            check("complete_idle", busy, 0);
            @(negedge clk);
            check("done_pulse_single", done, 0);
            repeat (3) @(negedge clk);
            check("status_hold", status, 1);
        end
    endtask

    // ackn == 0 means the responder never acknowledges.
    task automatic run_clear(input int ackn, input bit with_load);
        int n = 0, valid_seen = 0, dones = 0;
        cmd_clear = 1'b1;
        cmd_load  = with_load;
        key_in    = rand_key();
        @(negedge clk);
        cmd_clear = 1'b0;
        cmd_load  = 1'b0;
        check("clear_status_zero", status, 0);
        check("clear_busy", busy, 1);
        while (llkid_clear_key && n < 100) begin
            if (llkid_key_valid) valid_seen++;
            if (done) dones++;
            n++;
            if (n == ackn) llkid_clear_key_ack = 1'b1;
            @(negedge clk);
            llkid_clear_key_ack = 1'b0;
        end
        check("clear_key_cycles", 64'(n), (ackn != 0) ? ackn : TO);
        check("clear_no_valid", 64'(valid_seen + (llkid_key_valid ? 1 : 0)), 0);
        check("clear_no_early_done", 64'(dones), 0);
        check("clear_key_dropped", llkid_clear_key, 0);
        check("clear_idle", busy, 0);
        check("clear_done", done, (ackn != 0) ? 1 : 0);
        check("clear_status", status, (ackn != 0) ? 1 : 3);
        @(negedge clk);
        check("clear_done_pulse", done, 0);
    endtask

    initial begin
        logic [64*KW-1:0] k;
        rst                 = 1'b1;
        cmd_load            = 1'b0;
        cmd_clear           = 1'b0;
        key_in              = '0;
        llkid_key_ready     = 1'b0;
        llkid_key_complete  = 1'b0;
        llkid_clear_key_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", llkid_key_valid, 0);
        check("rst_data", llkid_key_data, 0);
        check("rst_clear", llkid_clear_key, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < KW; i++) k[64*i +: 64] = {8{8'(8'h11 * (i + 1))}};
        $display("step: directed load, ready held high");
        run_load(k, 0, 2, 0, 0);
        $display("step: load, ready 1,0,0,1 pattern");
        run_load(rand_key(), 1, 4, 0, 0);
        $display("step: load, random ready");
        run_load(rand_key(), 2, $urandom_range(0, 10), 0, 0);
        $display("step: load, stall up to the timeout boundary");
        run_load(rand_key(), 3, 0, 0, 0);
        $display("step: load, complete never asserted");
        run_load(rand_key(), 0, 0, 0, 1);
        $display("step: commands while busy are ignored");
        run_load(rand_key(), 0, 1, 1, 0);

        $display("step: load+clear same cycle, ack after 3");
        run_clear(3, 1);
        $display("step: clear, random ack delay");
        run_clear($urandom_range(1, 12), 0);
        $display("step: clear, ack never");
        run_clear(0, 0);

        $display("step: ready stuck low times out in send");
        key_in   = rand_key();
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        begin
            int n = 0;
            while (llkid_key_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("send_timeout_cycles", 64'(n), TO);
        end
        check("send_timeout_status", status, 2);
        check("send_timeout_done", done, 0);
        check("send_timeout_idle", busy, 0);

        $display("step: reset after two words");
        k        = rand_key();
        key_in   = k;
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_load        = 1'b0;
        llkid_key_ready = 1'b1;
        check("pre_rst_word0", llkid_key_data, k[63:0]);
        @(negedge clk);
        check("pre_rst_word1", llkid_key_data, k[127:64]);
        @(negedge clk);
        rst             = 1'b1;
        cmd_load        = 1'b1;
        llkid_key_ready = 1'b0;
        @(negedge clk);
        check("midrst_valid", llkid_key_valid, 0);
        check("midrst_data", llkid_key_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_status", status, 0);
        rst      = 1'b0;
        cmd_load = 1'b0;
        @(negedge clk);
        check("cmd_during_rst_ignored", busy, 0);
        run_load(rand_key(), 0, 3, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
